// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings, state type and instruction-class struct for the multi-cycle controller.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;
  localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR = 3'd4, ALU_SLT = 3'd5, ALU_SLTU = 3'd6;
  localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_JUMPR = 2'd3;
  localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_R31 = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011, F_JR = 6'b001000;
  typedef struct packed {
    logic r, addi, ori, lw, sw, beq, bne, j, jal, jr;
  } cls_t;
  // ALU_NOP doubles as "unsupported funct" for the R-type decode
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    return f[5:1] == 5'b10000 ? ALU_ADD :
           f[5:1] == 5'b10001 ? ALU_SUB :
           f == 6'b100100 ? ALU_AND :
           f == 6'b100101 ? ALU_OR :
           f == 6'b101010 ? ALU_SLT :
           f == 6'b101011 ? ALU_SLTU : ALU_NOP;
  endfunction
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: Op/Funct -> one-hot instruction class, illegal flag and R-type ALU op.
// jal/jr decode only when MC_CTRL_JLINK_EN is defined.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_ill,
  output logic [2:0] o_alu
);
  assign o_alu = funct_alu(i_funct);
  always_comb begin
    o_cls      = '0;
    o_cls.r    = i_op == OP_R && o_alu != ALU_NOP;
    o_cls.addi = i_op == OP_ADDI;
    o_cls.ori  = i_op == OP_ORI;
    o_cls.lw   = i_op == OP_LW;
    o_cls.sw   = i_op == OP_SW;
    o_cls.beq  = i_op == OP_BEQ;
    o_cls.bne  = i_op == OP_BNE;
    o_cls.j    = i_op == OP_J;
`ifdef MC_CTRL_JLINK_EN
    o_cls.jal  = i_op == OP_JAL;
    o_cls.jr   = i_op == OP_R && i_funct == F_JR;
`endif
    o_ill      = o_cls == '0;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller FSM (IF/ID/EXE/MEM/WB/ERR) with memory wait timeout.
// Define MC_CTRL_JLINK_EN to add jal/jr support.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       err_ill,
  output logic       err_tmo
);
  state_t r_state, w_next;
  logic [WAIT_W-1:0] r_cnt;
  logic r_ill, r_tmo;
  cls_t w_cls;
  logic w_ill, w_hit, w_wait;
  logic [2:0] w_ralu, w_alu;
  logic w_req, w_iord, w_mw, w_irw, w_pcw, w_rw, w_ext, w_src;
  logic [1:0] w_npc, w_gpr, w_wd;
  mc_ctrl_dec u_dec (
    .i_op(Op),
    .i_funct(Funct),
    .o_cls(w_cls),
    .o_ill(w_ill),
    .o_alu(w_ralu)
  );
  // rdy arriving on the deciding cycle is not a wait, so it beats the timeout
  assign w_hit  = r_cnt == WAIT_W'(WAIT_MAX - 1);
  assign w_wait = w_req && !mem_rdy;
  always_comb begin
    w_next = r_state;
    {w_req, w_iord, w_mw, w_irw, w_pcw, w_rw, w_ext, w_src} = '0;
    w_alu = ALU_NOP;
    w_npc = NPC_PLUS4;
    w_gpr = GPR_RD;
    w_wd  = WD_ALU;
    case (r_state)
      S_IF: begin
        w_req  = 1'b1;
        w_irw  = mem_rdy;
        w_pcw  = mem_rdy;
        w_next = mem_rdy ? S_ID : w_hit ? S_ERR : S_IF;
      end
      S_ID: begin
        w_pcw  = w_cls.j | w_cls.jr;
        w_npc  = w_cls.jr ? NPC_JUMPR : w_cls.j ? NPC_JUMP : NPC_PLUS4;
        w_next = w_ill ? S_ERR : (w_cls.j | w_cls.jr) ? S_IF : w_cls.jal ? S_WB : S_EXE;
      end
      S_EXE: begin
        w_src  = ~w_cls.r & ~w_cls.beq & ~w_cls.bne;
        w_ext  = w_cls.addi | w_cls.lw | w_cls.sw;
        w_alu  = w_cls.r ? w_ralu : w_cls.ori ? ALU_OR : (w_cls.beq | w_cls.bne) ? ALU_SUB : ALU_ADD;
        w_npc  = (w_cls.beq | w_cls.bne) ? NPC_BRANCH : NPC_PLUS4;
        w_pcw  = (w_cls.beq & Zero) | (w_cls.bne & ~Zero);
        w_next = (w_cls.lw | w_cls.sw) ? S_MEM : (w_cls.beq | w_cls.bne) ? S_IF : S_WB;
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_iord = 1'b1;
        w_mw   = w_cls.sw;
        w_next = mem_rdy ? (w_cls.lw ? S_WB : S_IF) : w_hit ? S_ERR : S_MEM;
      end
      S_WB: begin
        w_rw   = 1'b1;
        w_wd   = w_cls.lw ? WD_MEM : w_cls.jal ? WD_PC : WD_ALU;
        w_gpr  = w_cls.r ? GPR_RD : w_cls.jal ? GPR_R31 : GPR_RT;
        w_pcw  = w_cls.jal;
        w_npc  = w_cls.jal ? NPC_JUMP : NPC_PLUS4;
        w_next = S_IF;
      end
      default: w_next = S_ERR;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IF;
      r_cnt   <= '0;
      r_ill   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next != r_state ? '0 : r_cnt + WAIT_W'(w_wait);
      r_ill   <= r_ill | (r_state == S_ID && w_next == S_ERR);
      r_tmo   <= r_tmo | (w_wait && w_next == S_ERR);
    end
  end
  // reset forces every strobe low even though the held state is IF
  assign {mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc, ALUOp, NPCOp, GPRSel, WDSel} =
    rstn ? {w_req, w_iord, w_mw, w_irw, w_pcw, w_rw, w_ext, w_src, w_alu, w_npc, w_gpr, w_wd} : '0;
  assign state   = r_state;
  assign err_ill = r_ill;
  assign err_tmo = r_tmo;
endmodule
